// File: rtl/rvh_noc_pkg.sv
// Shared NoC router types: output-port encoding, decoded flit, and the
// stage-1 switch-allocation request handed to the output-port arbiter.
package rvh_noc_pkg;

  localparam int NOC_OUTPUT_PORT_NUM = 5;
  localparam int IO_PORT_W           = $clog2(NOC_OUTPUT_PORT_NUM);
  // Wide enough for any input port of up to 16 VCs.
  localparam int SA_VC_IDX_W         = 4;

  typedef logic [IO_PORT_W-1:0] io_port_t;

  typedef struct packed {
    io_port_t look_ahead_routing;
  } flit_dec_t;

  typedef struct packed {
    logic                   v;
    io_port_t               port;
    logic [SA_VC_IDX_W-1:0] vc_idx;
  } sa_stage1_req_t;

endpackage

// File: rtl/input_port_sa_vc_arbiter_one_hot_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i (wrapping),
// returned as a one-hot grant plus its index.
module one_hot_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_v_o
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_v_o   = |req_i;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % N]) begin
        gnt_o                           = '0;
        gnt_o[(int'(ptr_i) + i) % N]    = 1'b1;
        gnt_idx_o                       = IDX_W'((int'(ptr_i) + i) % N);
      end
    end
  end

endmodule

// File: rtl/input_port_sa_vc_arbiter.sv
// Switch-allocation stage 1: picks one VC per cycle, locks it for a whole
// packet. Define INPUT_PORT_SA_QOS_EN for qos-first selection in IDLE.
module input_port_sa_vc_arbiter
  import rvh_noc_pkg::*;
#(
  parameter int VC_NUM          = 4,
  parameter int OUTPUT_PORT_NUM = 5,
  parameter int QOS_VALUE_W     = 4,
  localparam int VC_IDX_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [VC_NUM-1:0]                   vc_flit_v_i,
  input  flit_dec_t [VC_NUM-1:0]              vc_flit_dec_i,
  input  logic [VC_NUM-1:0]                   vc_flit_is_tail_i,
  input  logic [OUTPUT_PORT_NUM-1:0]          out_credit_avail_i,
`ifdef INPUT_PORT_SA_QOS_EN
  input  logic [VC_NUM-1:0][QOS_VALUE_W-1:0]  vc_qos_value_i,
`endif
  output logic                                sa_req_v_o,
  output io_port_t                            sa_req_port_o,
  output logic [VC_IDX_W-1:0]                 sa_req_vc_idx_o,
  input  logic                                sa_gnt_i,
  output logic [VC_NUM-1:0]                   vc_pop_o,
  output logic                                lock_v_o
);

  logic                lock_v_q, lock_v_d;
  logic [VC_IDX_W-1:0] lock_vc_q, lock_vc_d;
  logic [VC_IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [VC_NUM-1:0]   elig, arb_req, arb_gnt;
  logic [VC_IDX_W-1:0] arb_idx, sel_idx;
  logic                arb_v, gnt;
  sa_stage1_req_t      req;

  // Encodings beyond the last real port are treated as creditless.
  always_comb begin
    elig = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      elig[v] = vc_flit_v_i[v]
             && (int'(vc_flit_dec_i[v].look_ahead_routing) < OUTPUT_PORT_NUM)
             && out_credit_avail_i[vc_flit_dec_i[v].look_ahead_routing];
    end
  end

`ifdef INPUT_PORT_SA_QOS_EN
  logic [QOS_VALUE_W-1:0] max_qos;
  always_comb begin
    max_qos = '0;
    arb_req = '0;
    for (int v = 0; v < VC_NUM; v++)
      if (elig[v] && vc_qos_value_i[v] > max_qos) max_qos = vc_qos_value_i[v];
    for (int v = 0; v < VC_NUM; v++)
      arb_req[v] = elig[v] && (vc_qos_value_i[v] == max_qos);
  end
`else
  assign arb_req = elig;
`endif

  one_hot_rr_arbiter #(.N(VC_NUM), .IDX_W(VC_IDX_W)) u_vc_rr (
    .req_i    (arb_req),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (arb_gnt),
    .gnt_idx_o(arb_idx),
    .gnt_v_o  (arb_v)
  );

  // Outputs are forced quiet while reset is held, even with live inputs.
  always_comb begin
    req     = '0;
    sel_idx = lock_v_q ? lock_vc_q : arb_idx;
    if (!rst) begin
      req.v = lock_v_q ? elig[lock_vc_q] : arb_v;
      if (req.v) begin
        req.port   = vc_flit_dec_i[sel_idx].look_ahead_routing;
        req.vc_idx = SA_VC_IDX_W'(sel_idx);
      end
    end
  end

  assign gnt             = sa_gnt_i & req.v;
  assign sa_req_v_o      = req.v;
  assign sa_req_port_o   = req.port;
  assign sa_req_vc_idx_o = VC_IDX_W'(req.vc_idx);
  assign lock_v_o        = lock_v_q;

  always_comb begin
    vc_pop_o = '0;
    if (gnt) begin
      if (lock_v_q) vc_pop_o[lock_vc_q] = 1'b1;
      else          vc_pop_o            = arb_gnt;
    end
  end

  always_comb begin
    lock_v_d  = lock_v_q;
    lock_vc_d = lock_vc_q;
    rr_ptr_d  = rr_ptr_q;
    if (gnt) begin
      if (vc_flit_is_tail_i[sel_idx]) begin
        lock_v_d = 1'b0;
        rr_ptr_d = (sel_idx == VC_IDX_W'(VC_NUM - 1)) ? '0 : sel_idx + 1'b1;
      end else begin
        lock_v_d  = 1'b1;
        lock_vc_d = sel_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_v_q  <= 1'b0;
      lock_vc_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      lock_v_q  <= lock_v_d;
      lock_vc_q <= lock_vc_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // A grant without a request is dropped; flag it in simulation.
  a_gnt_needs_req: assert property (@(posedge clk) disable iff (rst) sa_gnt_i |-> sa_req_v_o);

endmodule

// File: tb/tb_input_port_sa_vc_arbiter.sv
// Scoreboard bench for input_port_sa_vc_arbiter (VC_NUM=4, 5 output ports).
module tb_input_port_sa_vc_arbiter;
  import rvh_noc_pkg::*;

  logic            clk, rst;
  logic [3:0]      vc_flit_v, vc_tail, vc_pop;
  flit_dec_t [3:0] vc_dec;
  logic [4:0]      credit;
  logic            gnt_en, sa_gnt, req_v, lock_v;
  io_port_t        req_port;
  logic [1:0]      req_idx;
`ifdef INPUT_PORT_SA_QOS_EN
  logic [3:0][3:0] qos;
`endif

  typedef struct packed {
    logic       req;
    logic [1:0] idx;
    logic [2:0] port;
    logic [3:0] pop;
    logic       lock;
  } exp_t;

  exp_t exp_q[$];
  exp_t e, o;
  int   total = 0;
  int   bad   = 0;

  input_port_sa_vc_arbiter #(.VC_NUM(4), .OUTPUT_PORT_NUM(5), .QOS_VALUE_W(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .vc_flit_v_i       (vc_flit_v),
    .vc_flit_dec_i     (vc_dec),
    .vc_flit_is_tail_i (vc_tail),
    .out_credit_avail_i(credit),
`ifdef INPUT_PORT_SA_QOS_EN
    .vc_qos_value_i    (qos),
`endif
    .sa_req_v_o        (req_v),
    .sa_req_port_o     (req_port),
    .sa_req_vc_idx_o   (req_idx),
    .sa_gnt_i          (sa_gnt),
    .vc_pop_o          (vc_pop),
    .lock_v_o          (lock_v)
  );

  // Stage-2 stand-in: grants whatever is requested while enabled.
  assign sa_gnt = gnt_en & req_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus at the falling edge and queue its expectation.
  task automatic apply(input logic r, input logic [3:0] v, input logic [3:0] t,
                       input int p3, input int p2, input int p1, input int p0,
                       input logic [4:0] c, input logic g,
                       input logic er, input int ei, input int ep,
                       input logic [3:0] epop, input logic el);
    @(negedge clk);
    rst       = r;
    vc_flit_v = v;
    vc_tail   = t;
    vc_dec[3].look_ahead_routing = io_port_t'(p3);
    vc_dec[2].look_ahead_routing = io_port_t'(p2);
    vc_dec[1].look_ahead_routing = io_port_t'(p1);
    vc_dec[0].look_ahead_routing = io_port_t'(p0);
    credit    = c;
    gnt_en    = g;
    exp_q.push_back('{req: er, idx: 2'(ei), port: 3'(ep), pop: epop, lock: el});
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1, 4'b1010, 4'b1111, 2, 2, 2, 2, 5'h1f, 1, 0, 0, 0, 4'b0000, 0);
      #1;
      e = exp_q.pop_front();
      o = '{req: req_v, idx: req_idx, port: req_port, pop: vc_pop, lock: lock_v};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset row%0d: got req=%b idx=%0d port=%0d pop=%b lock=%b want req=%b idx=%0d port=%0d pop=%b lock=%b",
                 i, o.req, o.idx, o.port, o.pop, o.lock, e.req, e.idx, e.port, e.pop, e.lock);
      end
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) begin
      apply(0, 4'b1010, 4'b1111, 2, 2, 2, 2, 5'h1f, 1,
            1, (i % 2 == 0) ? 1 : 3, 2, (i % 2 == 0) ? 4'b0010 : 4'b1000, 0);
      #1;
      e = exp_q.pop_front();
      o = '{req: req_v, idx: req_idx, port: req_port, pop: vc_pop, lock: lock_v};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL round_robin row%0d: got req=%b idx=%0d port=%0d pop=%b lock=%b want req=%b idx=%0d port=%0d pop=%b lock=%b",
                 i, o.req, o.idx, o.port, o.pop, o.lock, e.req, e.idx, e.port, e.pop, e.lock);
      end
    end
  endtask

  task automatic test_packet_lock();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: apply(0, 4'b0101, 4'b0100, 0, 3, 0, 1, 5'h1f, 1, 1, 0, 1, 4'b0001, 0);
        1: apply(0, 4'b0101, 4'b0100, 0, 3, 0, 1, 5'h1f, 1, 1, 0, 1, 4'b0001, 1);
        2: apply(0, 4'b0101, 4'b0101, 0, 3, 0, 1, 5'h1f, 1, 1, 0, 1, 4'b0001, 1);
        default: apply(0, 4'b0100, 4'b0100, 0, 3, 0, 1, 5'h1f, 1, 1, 2, 3, 4'b0100, 0);
      endcase
      #1;
      e = exp_q.pop_front();
      o = '{req: req_v, idx: req_idx, port: req_port, pop: vc_pop, lock: lock_v};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL packet_lock row%0d: got req=%b idx=%0d port=%0d pop=%b lock=%b want req=%b idx=%0d port=%0d pop=%b lock=%b",
                 i, o.req, o.idx, o.port, o.pop, o.lock, e.req, e.idx, e.port, e.pop, e.lock);
      end
    end
  endtask

  task automatic test_lock_stall();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: apply(0, 4'b0011, 4'b0010, 0, 0, 2, 0, 5'h1f, 1, 1, 0, 0, 4'b0001, 0);
        1, 2: apply(0, 4'b0010, 4'b0010, 0, 0, 2, 0, 5'h1f, 1, 0, 0, 0, 4'b0000, 1);
        3: apply(0, 4'b0011, 4'b0010, 0, 0, 2, 0, 5'h1f, 1, 1, 0, 0, 4'b0001, 1);
        4: apply(0, 4'b0011, 4'b0011, 0, 0, 2, 0, 5'h1f, 1, 1, 0, 0, 4'b0001, 1);
        default: apply(0, 4'b0010, 4'b0010, 0, 0, 2, 0, 5'h1f, 1, 1, 1, 2, 4'b0010, 0);
      endcase
      #1;
      e = exp_q.pop_front();
      o = '{req: req_v, idx: req_idx, port: req_port, pop: vc_pop, lock: lock_v};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL lock_stall row%0d: got req=%b idx=%0d port=%0d pop=%b lock=%b want req=%b idx=%0d port=%0d pop=%b lock=%b",
                 i, o.req, o.idx, o.port, o.pop, o.lock, e.req, e.idx, e.port, e.pop, e.lock);
      end
    end
  endtask

  task automatic test_credit();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: apply(0, 4'b0100, 4'b1111, 0, 4, 0, 1, 5'b01111, 1, 0, 0, 0, 4'b0000, 0);
        1: apply(0, 4'b0101, 4'b1111, 0, 4, 0, 1, 5'b01111, 1, 1, 0, 1, 4'b0001, 0);
        2: apply(0, 4'b0100, 4'b1111, 0, 4, 0, 1, 5'b11111, 0, 1, 2, 4, 4'b0000, 0);
        default: apply(0, 4'b0100, 4'b1111, 0, 4, 0, 1, 5'b11111, 1, 1, 2, 4, 4'b0100, 0);
      endcase
      #1;
      e = exp_q.pop_front();
      o = '{req: req_v, idx: req_idx, port: req_port, pop: vc_pop, lock: lock_v};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL credit row%0d: got req=%b idx=%0d port=%0d pop=%b lock=%b want req=%b idx=%0d port=%0d pop=%b lock=%b",
                 i, o.req, o.idx, o.port, o.pop, o.lock, e.req, e.idx, e.port, e.pop, e.lock);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: apply(0, 4'b1011, 4'b0000, 2, 0, 3, 1, 5'h1f, 1, 1, 3, 2, 4'b1000, 0);
        1: apply(0, 4'b1011, 4'b0000, 2, 0, 3, 1, 5'h1f, 1, 1, 3, 2, 4'b1000, 1);
        2: apply(1, 4'b1011, 4'b0000, 2, 0, 3, 1, 5'h1f, 1, 0, 0, 0, 4'b0000, 0);
        3: apply(0, 4'b1011, 4'b1011, 2, 0, 3, 1, 5'h1f, 1, 1, 0, 1, 4'b0001, 0);
        default: apply(0, 4'b1011, 4'b1011, 2, 0, 3, 1, 5'h1f, 1, 1, 1, 3, 4'b0010, 0);
      endcase
      #1;
      e = exp_q.pop_front();
      o = '{req: req_v, idx: req_idx, port: req_port, pop: vc_pop, lock: lock_v};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_mid_packet row%0d: got req=%b idx=%0d port=%0d pop=%b lock=%b want req=%b idx=%0d port=%0d pop=%b lock=%b",
                 i, o.req, o.idx, o.port, o.pop, o.lock, e.req, e.idx, e.port, e.pop, e.lock);
      end
    end
  endtask

`ifdef INPUT_PORT_SA_QOS_EN
  // Entered with rr_ptr=2 (left there by the mid-packet reset test).
  task automatic test_qos();
    qos = '{4'd0, 4'd7, 4'd7, 4'd3};
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: apply(0, 4'b0111, 4'b1111, 0, 0, 0, 0, 5'h1f, 1, 1, 2, 0, 4'b0100, 0);
        1: apply(0, 4'b0011, 4'b1111, 0, 0, 0, 0, 5'h1f, 1, 1, 1, 0, 4'b0010, 0);
        default: apply(0, 4'b0001, 4'b1111, 0, 0, 0, 0, 5'h1f, 1, 1, 0, 0, 4'b0001, 0);
      endcase
      #1;
      e = exp_q.pop_front();
      o = '{req: req_v, idx: req_idx, port: req_port, pop: vc_pop, lock: lock_v};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL qos row%0d: got req=%b idx=%0d port=%0d pop=%b lock=%b want req=%b idx=%0d port=%0d pop=%b lock=%b",
                 i, o.req, o.idx, o.port, o.pop, o.lock, e.req, e.idx, e.port, e.pop, e.lock);
      end
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    vc_flit_v = '0;
    vc_tail   = '0;
    vc_dec    = '0;
    credit    = '0;
    gnt_en    = 1'b0;
`ifdef INPUT_PORT_SA_QOS_EN
    qos       = '0;
`endif
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_lock_stall();
    test_credit();
    test_reset_mid_packet();
`ifdef INPUT_PORT_SA_QOS_EN
    test_qos();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
